// File: rtl/md_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package md_pkg;

   localparam int unsigned DIV_LAT = 32;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDiv  = 2'd2
   } md_state_e;

   // Magnitude of a value, or the raw value for unsigned ops.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes, one quotient bit per enabled edge.
// quot/rem present the result of the step taken on the coming edge, so the owner can capture the
// final step's result on the same edge that performs it.
module muldiv_div_core
   import md_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        en,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quot,
   output logic [31:0] rem,
   output logic        last
);

   logic [31:0] q_q, q_d;
   logic [31:0] r_q, r_d;
   logic [31:0] d_q, d_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [32:0] shifted;
   logic [32:0] diff;

   always_comb begin
      shifted = {r_q, q_q[31]};
      diff    = shifted - {1'b0, d_q};
      // Borrow out of the 33-bit subtract means the trial subtraction must be restored.
      if (diff[32]) begin
         quot = {q_q[30:0], 1'b0};
         rem  = shifted[31:0];
      end else begin
         quot = {q_q[30:0], 1'b1};
         rem  = diff[31:0];
      end
      last = (cnt_q == 5'(DIV_LAT - 1));
   end

   always_comb begin
      q_d   = q_q;
      r_d   = r_q;
      d_d   = d_q;
      cnt_d = cnt_q;
      if (load) begin
         q_d   = dividend;
         r_d   = '0;
         d_d   = divisor;
         cnt_d = '0;
      end else if (en) begin
         q_d   = quot;
         r_d   = rem;
         cnt_d = cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q   <= '0;
         r_q   <= '0;
         d_q   <= '0;
         cnt_q <= '0;
      end else begin
         q_q   <= q_d;
         r_q   <= r_d;
         d_q   <= d_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Multiply is a fixed-latency product pipeline; divide uses the iterative restoring core.
module ex_muldiv_unit
   import md_pkg::*;
#(
   parameter int unsigned MULT_LAT = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        hold,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e   state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] a_q, a_d;
   logic        dz_q, dz_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic [63:0] prod_q [MULT_LAT];
   logic [63:0] prod_d [MULT_LAT];

   logic        accept;
   logic        op_signed;
   logic        is_div;
   logic signed [63:0] mul_a, mul_b;
   logic [63:0] product;
   logic [31:0] div_quot, div_rem;
   logic        div_last;

   assign accept    = start & ~hold & (state_q == StIdle);
   assign op_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
   assign is_div    = (md_op == MD_DIV) || (md_op == MD_DIVU);

   always_comb begin
      mul_a   = {{32{op_signed & src_a[31]}}, src_a};
      mul_b   = {{32{op_signed & src_b[31]}}, src_b};
      product = 64'(mul_a * mul_b);
   end

   muldiv_div_core u_div_core (
      .clk      (clk),
      .rst      (rst),
      .load     (accept & is_div),
      .en       (~hold & (state_q == StDiv)),
      .dividend (mag32(src_a, op_signed)),
      .divisor  (mag32(src_b, op_signed)),
      .quot     (div_quot),
      .rem      (div_rem),
      .last     (div_last)
   );

   // Product pipeline: loaded on accept, advanced on every non-held edge.
   always_comb begin
      for (int i = 0; i < MULT_LAT; i++) begin
         prod_d[i] = prod_q[i];
      end
      if (!hold) begin
         for (int i = 1; i < MULT_LAT; i++) begin
            prod_d[i] = prod_q[i-1];
         end
         if (accept) begin
            prod_d[0] = product;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      dz_d    = dz_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      if (!hold) begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  case (md_op)
                     MD_MULT, MD_MULTU: begin
                        state_d = StMul;
                        cnt_d   = 3'(MULT_LAT - 1);
                     end
                     MD_DIV, MD_DIVU: begin
                        state_d = StDiv;
                        a_d     = src_a;
                        dz_d    = (src_b == 32'd0);
                        qneg_d  = op_signed & (src_a[31] ^ src_b[31]);
                        rneg_d  = op_signed & src_a[31];
                     end
                     MD_MTHI: hi_d = src_a;
                     MD_MTLO: lo_d = src_a;
                     default: ;
                  endcase
               end
            end
            StMul: begin
               if (cnt_q == 3'd0) begin
                  {hi_d, lo_d} = prod_q[MULT_LAT-1];
                  state_d      = StIdle;
                  done_d       = 1'b1;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            StDiv: begin
               if (div_last) begin
                  if (dz_q) begin
                     lo_d = 32'hFFFF_FFFF;
                     hi_d = a_q;
                  end else begin
                     lo_d = qneg_q ? (~div_quot + 32'd1) : div_quot;
                     hi_d = rneg_q ? (~div_rem + 32'd1) : div_rem;
                  end
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         dz_q    <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         for (int i = 0; i < MULT_LAT; i++) begin
            prod_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         dz_q    <= dz_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         for (int i = 0; i < MULT_LAT; i++) begin
            prod_q[i] <= prod_d[i];
         end
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed corner cases plus random mul/div traffic.
module tb_ex_muldiv_unit;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] src_a, src_b;
   logic        hold;
   logic        busy, done;
   logic [31:0] hi, lo;

   typedef struct {
      logic [63:0] hilo;
      int          lat;
   } exp_t;

   exp_t scb[$];
   int   errors = 0;
   int   checks = 0;
   int   busy_cnt = 0;

   ex_muldiv_unit #(.MULT_LAT(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .md_op (md_op),
      .src_a (src_a),
      .src_b (src_b),
      .hold  (hold),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference {hi,lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub;
      logic [63:0]     qv, rv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd1: return 64'(sa * sb);
         3'd2: return ua * ub;
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q  = sa / sb;
            r  = sa % sb;
            qv = q;
            rv = r;
            return {rv[31:0], qv[31:0]};
         end
         3'd4: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            qv = ua / ub;
            rv = ua % ub;
            return {rv[31:0], qv[31:0]};
         end
         default: return 64'd0;
      endcase
   endfunction

   // Monitor: measures each busy run and checks it together with the result at done.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (scb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done: got done=1 expected no pending op");
            end else begin
               e = scb.pop_front();
               chk("hilo", {hi, lo}, e.hilo);
               chk("busy_cycles", 64'(busy_cnt), 64'(e.lat));
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 80);
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: got busy=1 expected 0 within 80 cycles");
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold_at, input int hold_n);
      exp_t e;
      int   lat;
      lat = (op == 3'd1 || op == 3'd2) ? 5 : ((op == 3'd3 || op == 3'd4) ? DIV_LAT : 0);
      if (lat > 0) begin
         e.hilo = ref_md(op, a, b);
         e.lat  = lat + hold_n;
         scb.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b1; md_op = op; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0; src_a = $urandom; src_b = $urandom;
      if (op == 3'd5) chk("mthi", {32'd0, hi}, {32'd0, a});
      if (op == 3'd6) chk("mtlo", {32'd0, lo}, {32'd0, a});
      if (hold_n > 0) begin
         repeat (hold_at) @(posedge clk);
         #1 hold = 1'b1;
         repeat (hold_n) @(posedge clk);
         #1 hold = 1'b0;
      end
      if (lat > 0) wait_idle();
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'd0;
         1: v = 32'hFFFF_FFFF;
         2: v = 32'h8000_0000;
         3: v = $urandom_range(0, 20);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish within 2ms");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; md_op = 3'd0; src_a = '0; src_b = '0; hold = 1'b0;
      #12;
      chk("reset_state", {29'd0, busy, done, 1'b0, hi, lo}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      issue(3'd1, 32'hFFFF_FFFD, 32'd7, 0, 0);
      issue(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 0);
      issue(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
      issue(3'd4, 32'd7, 32'd0, 0, 0);
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      issue(3'd3, 32'd100, 32'd7, 10, 3);
      issue(3'd1, 32'h1234_5678, 32'h8765_4321, 1, 2);
      issue(3'd5, 32'hCAFE_F00D, 32'd0, 0, 0);

      // MTLO then a MULT; an MTLO attempted while busy must be ignored.
      issue(3'd6, 32'h0000_1234, 32'd0, 0, 0);
      begin
         exp_t e;
         e.hilo = ref_md(3'd1, 32'd3, 32'd5);
         e.lat  = 5;
         scb.push_back(e);
         @(posedge clk); #1;
         start = 1'b1; md_op = 3'd1; src_a = 32'd3; src_b = 32'd5;
         @(posedge clk); #1;
         md_op = 3'd6; src_a = 32'hDEAD_BEEF;
         @(posedge clk); #1;
         start = 1'b0; md_op = 3'd0;
         #1 chk("mtlo_ignored_while_busy", {31'd0, busy, lo}, {31'd0, 1'b1, 32'h0000_1234});
         wait_idle();
      end

      for (int i = 0; i < 40; i++) begin
         issue(3'($urandom_range(1, 4)), pick_operand(), pick_operand(), 0, 0);
      end

      // Reset in the middle of a divide: state clears at once, no done follows.
      issue(3'd6, 32'h5555_AAAA, 32'd0, 0, 0);
      @(posedge clk); #1;
      start = 1'b1; md_op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("reset_mid_div", {31'd0, busy, hi | lo}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (40) @(posedge clk);
      #1 chk("post_reset_idle", {31'd0, busy, hi | lo}, 64'd0);

      chk("scoreboard_drained", 64'(scb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
